// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the dual-clock FIFO write/read controllers.
package fifo_pkg;

    // Default memory address width; pointers carry one extra wrap bit.
    localparam int unsigned ADD_WIDTH_DEF = 3;
    localparam int unsigned PTR_W         = ADD_WIDTH_DEF + 1;

    // Working width of the code converters; any pointer up to this width
    // is zero-extended in and truncated back out by the caller.
    localparam int unsigned CODE_W = 32;

    // Binary to reflected Gray code.
    function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reflected Gray code to binary (prefix XOR from the MSB down).
    function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] g);
        logic [CODE_W-1:0] b;
        b[CODE_W-1] = g[CODE_W-1];
        for (int i = CODE_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing clock domains.
module ptr_sync #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    // Shift the foreign pointer through the flop chain; sync reset clears all stages.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int unsigned i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/wr_ptr_full.sv
// Write-domain pointer and full/almost-full/level/overflow status for the async FIFO.
module wr_ptr_full
    import fifo_pkg::*;
#(
    parameter int unsigned ADD_WIDTH   = ADD_WIDTH_DEF,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AF_LEVEL    = 6
) (
    input  logic                 wr_clk,
    input  logic                 wr_rst,
    input  logic                 wr_en,
    input  logic [ADD_WIDTH:0]   rd_ptr_gray,
    output logic [ADD_WIDTH-1:0] wr_addrs,
    output logic                 wr_accept,
    output logic [ADD_WIDTH:0]   wr_ptr_gray,
    output logic                 wr_full,
    output logic                 wr_almost_full,
    output logic [ADD_WIDTH:0]   wr_level,
    output logic                 wr_overflow
);

    localparam int unsigned PW = ADD_WIDTH + 1;

    logic [PW-1:0] bin_q, bin_d;
    logic [PW-1:0] gray_q, gray_d;
    logic [PW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          af_q, af_d;
    logic          ovf_q, ovf_d;
    logic          accept_c;
    logic [PW-1:0] rq;
    logic [PW-1:0] rq_bin;
    logic [PW-1:0] full_cmp;

    // Bring the read pointer into the write domain (Gray only crosses).
    ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_rd_sync (
        .clk_i  (wr_clk),
        .rst_ni (wr_rst),
        .d_i    (rd_ptr_gray),
        .q_o    (rq)
    );

    // Next pointer and status, all computed from the post-edge pointer.
    always_comb begin
        accept_c = wr_en & ~full_q & wr_rst;
        bin_d    = bin_q + PW'(accept_c);
        gray_d   = PW'(bin2gray(CODE_W'(bin_d)));
        rq_bin   = PW'(gray2bin(CODE_W'(rq)));
        // Full when write is exactly one lap ahead: top two Gray bits inverted.
        full_cmp = rq ^ (PW'(3) << (PW - 2));
        full_d   = (gray_d == full_cmp);
        level_d  = bin_d - rq_bin;
        af_d     = (level_d >= PW'(AF_LEVEL));
        ovf_d    = ovf_q | (wr_en & full_q);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge wr_clk) begin
        if (!wr_rst) begin
            bin_q   <= '0;
            gray_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            level_q <= level_d;
            full_q  <= full_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wr_addrs       = bin_q[ADD_WIDTH-1:0];
    assign wr_accept      = accept_c;
    assign wr_ptr_gray    = gray_q;
    assign wr_full        = full_q;
    assign wr_almost_full = af_q;
    assign wr_level       = level_q;
    assign wr_overflow    = ovf_q;

endmodule
